// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Forward-select encodings and hazard FSM states shared by the
//            ID-stage hazard/forwarding controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_EALU = 2'b01;
  localparam logic [1:0] FWD_MALU = 2'b10;
  localparam logic [1:0] FWD_MMO  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_fwd_sel.sv
// ============================================================================
// Module   : pipe_fwd_sel
// Purpose  : Per-operand forward select, operand mux and load-use hit flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_fwd_sel
  import pipe_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic [AW-1:0] i_src,
  input  logic          i_use,
  input  logic [DW-1:0] i_q,
  input  logic [AW-1:0] i_e_rn,
  input  logic          i_e_wreg,
  input  logic          i_e_m2reg,
  input  logic [DW-1:0] i_e_alu,
  input  logic [AW-1:0] i_m_rn,
  input  logic          i_m_wreg,
  input  logic          i_m_m2reg,
  input  logic [DW-1:0] i_m_alu,
  input  logic [DW-1:0] i_m_mo,
  output logic [1:0]    o_sel,
  output logic [DW-1:0] o_data,
  output logic          o_ld_hit
);

  logic w_e_match;
  logic w_m_match;

  // r0 is hardwired to zero, so it never matches a producer
  assign w_e_match = i_e_wreg && (i_e_rn != '0) && (i_e_rn == i_src);
  assign w_m_match = i_m_wreg && (i_m_rn != '0) && (i_m_rn == i_src);

  // A load in E has no data yet; it can only stall, never forward
  assign o_ld_hit = i_use && w_e_match && i_e_m2reg;

  always_comb begin
    o_sel = FWD_REG;
    if (w_e_match && !i_e_m2reg) begin
      o_sel = FWD_EALU;
    end else if (w_m_match) begin
      o_sel = i_m_m2reg ? FWD_MMO : FWD_MALU;
    end
  end

  always_comb begin
    o_data = i_q;
    case (o_sel)
      FWD_EALU: o_data = i_e_alu;
      FWD_MALU: o_data = i_m_alu;
      FWD_MMO:  o_data = i_m_mo;
      default:  o_data = i_q;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : ID-stage operand forwarding, multi-cycle load-use interlock,
//            branch flush and saturating stall counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int LD_LAT = 1,
  parameter int CW     = 16
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic          d_use_rs,
  input  logic          d_use_rt,
  input  logic [DW-1:0] q1,
  input  logic [DW-1:0] q2,
  input  logic [AW-1:0] e_rn,
  input  logic          e_wreg,
  input  logic          e_m2reg,
  input  logic [DW-1:0] e_alu,
  input  logic [AW-1:0] m_rn,
  input  logic          m_wreg,
  input  logic          m_m2reg,
  input  logic [DW-1:0] m_alu,
  input  logic [DW-1:0] m_mo,
  input  logic          branch_taken,
  output logic [DW-1:0] da,
  output logic [DW-1:0] db,
  output logic [1:0]    fwda,
  output logic [1:0]    fwdb,
  output logic          wpcir,
  output logic          dbubble,
  output logic          flush,
  output logic [CW-1:0] stall_cnt
);

  localparam bit          c_MULTI     = (LD_LAT > 1);
  localparam logic [2:0]  c_WAIT_INIT = 3'(LD_LAT - 1);
  localparam logic [CW-1:0] c_CNT_MAX = {CW{1'b1}};

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_wait;
  logic [2:0]    w_wait_nxt;
  logic [CW-1:0] r_stall_cnt;
  logic          w_hit_a;
  logic          w_hit_b;
  logic          w_hz;
  logic          w_wpcir;

  pipe_fwd_sel #(.DW(DW), .AW(AW)) u_fwd_a (
    .i_src    (d_rs),
    .i_use    (d_use_rs),
    .i_q      (q1),
    .i_e_rn   (e_rn),
    .i_e_wreg (e_wreg),
    .i_e_m2reg(e_m2reg),
    .i_e_alu  (e_alu),
    .i_m_rn   (m_rn),
    .i_m_wreg (m_wreg),
    .i_m_m2reg(m_m2reg),
    .i_m_alu  (m_alu),
    .i_m_mo   (m_mo),
    .o_sel    (fwda),
    .o_data   (da),
    .o_ld_hit (w_hit_a)
  );

  pipe_fwd_sel #(.DW(DW), .AW(AW)) u_fwd_b (
    .i_src    (d_rt),
    .i_use    (d_use_rt),
    .i_q      (q2),
    .i_e_rn   (e_rn),
    .i_e_wreg (e_wreg),
    .i_e_m2reg(e_m2reg),
    .i_e_alu  (e_alu),
    .i_m_rn   (m_rn),
    .i_m_wreg (m_wreg),
    .i_m_m2reg(m_m2reg),
    .i_m_alu  (m_alu),
    .i_m_mo   (m_mo),
    .o_sel    (fwdb),
    .o_data   (db),
    .o_ld_hit (w_hit_b)
  );

  assign w_hz = w_hit_a || w_hit_b;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_wait      <= 3'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (!w_wpcir && (r_stall_cnt != c_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  // The first stall cycle is spent in IDLE; WAIT covers the remaining LD_LAT-1
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_wpcir     = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_hz) begin
          w_wpcir = 1'b0;
          if (c_MULTI) begin
            w_state_nxt = ST_WAIT;
            w_wait_nxt  = c_WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        w_wpcir    = 1'b0;
        w_wait_nxt = r_wait - 3'd1;
        if (r_wait == 3'd1) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_wait_nxt  = 3'd0;
      end
    endcase
  end

  // The branch itself proceeds into E; only its IF/ID successor is killed
  assign wpcir     = w_wpcir;
  assign dbubble   = ~w_wpcir;
  assign flush     = branch_taken & w_wpcir;
  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl (LD_LAT=1 and LD_LAT=3/CW=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [4:0]  d_rs = '0, d_rt = '0, e_rn = '0, m_rn = '0;
  logic        d_use_rs = 1'b0, d_use_rt = 1'b0;
  logic        e_wreg = 1'b0, e_m2reg = 1'b0, m_wreg = 1'b0, m_m2reg = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] q1 = '0, q2 = '0, e_alu = '0, m_alu = '0, m_mo = '0;

  logic [31:0] da1, db1, da3, db3;
  logic [1:0]  fwda1, fwdb1, fwda3, fwdb3;
  logic        wpcir1, dbubble1, flush1, wpcir3, dbubble3, flush3;
  logic [15:0] sc1;
  logic [3:0]  sc3;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.DW(32), .AW(5), .LD_LAT(1), .CW(16)) dut1 (
    .clock(clock), .resetn(resetn), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .q1(q1), .q2(q2),
    .e_rn(e_rn), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_alu(e_alu),
    .m_rn(m_rn), .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_alu(m_alu), .m_mo(m_mo),
    .branch_taken(branch_taken), .da(da1), .db(db1), .fwda(fwda1), .fwdb(fwdb1),
    .wpcir(wpcir1), .dbubble(dbubble1), .flush(flush1), .stall_cnt(sc1)
  );

  pipe_hazard_ctrl #(.DW(32), .AW(5), .LD_LAT(3), .CW(4)) dut3 (
    .clock(clock), .resetn(resetn), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .q1(q1), .q2(q2),
    .e_rn(e_rn), .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_alu(e_alu),
    .m_rn(m_rn), .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_alu(m_alu), .m_mo(m_mo),
    .branch_taken(branch_taken), .da(da3), .db(db3), .fwda(fwda3), .fwdb(fwdb3),
    .wpcir(wpcir3), .dbubble(dbubble3), .flush(flush3), .stall_cnt(sc3)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_sel(input logic [4:0] src);
    if (e_wreg && e_rn != 0 && e_rn == src && !e_m2reg) return 2'b01;
    if (m_wreg && m_rn != 0 && m_rn == src) return m_m2reg ? 2'b11 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] ref_data(input logic [1:0] sel, input logic [31:0] q);
    case (sel)
      2'b01:   return e_alu;
      2'b10:   return m_alu;
      2'b11:   return m_mo;
      default: return q;
    endcase
  endfunction

  function automatic bit ref_hz();
    return e_wreg && e_m2reg && e_rn != 0 &&
           ((d_use_rs && e_rn == d_rs) || (d_use_rt && e_rn == d_rt));
  endfunction

  // stall cycles still owed after the current one, and expected counters
  int rem1 = 0, rem3 = 0, cnt1 = 0, cnt3 = 0;

  always @(negedge clock) begin
    bit h, wp1, wp3;
    logic [1:0] sa, sb;
    if (!resetn) begin
      rem1 = 0; rem3 = 0; cnt1 = 0; cnt3 = 0;
    end
    h   = ref_hz();
    sa  = ref_sel(d_rs);
    sb  = ref_sel(d_rt);
    wp1 = !(rem1 > 0 || h);
    wp3 = !(rem3 > 0 || h);
    chk("fwda1", fwda1, sa);
    chk("fwdb1", fwdb1, sb);
    chk("da1", da1, ref_data(sa, q1));
    chk("db1", db1, ref_data(sb, q2));
    chk("wpcir1", wpcir1, wp1);
    chk("dbubble1", dbubble1, !wp1);
    chk("flush1", flush1, branch_taken && wp1);
    chk("stall_cnt1", sc1, cnt1);
    chk("fwda3", fwda3, sa);
    chk("fwdb3", fwdb3, sb);
    chk("da3", da3, ref_data(sa, q1));
    chk("db3", db3, ref_data(sb, q2));
    chk("wpcir3", wpcir3, wp3);
    chk("dbubble3", dbubble3, !wp3);
    chk("flush3", flush3, branch_taken && wp3);
    chk("stall_cnt3", sc3, cnt3);
    if (resetn) begin
      if (!wp1) cnt1 = (cnt1 == 65535) ? 65535 : cnt1 + 1;
      if (!wp3) cnt3 = (cnt3 == 15) ? 15 : cnt3 + 1;
      if (rem1 > 0) rem1--; else if (h) rem1 = 0;
      if (rem3 > 0) rem3--; else if (h) rem3 = 2;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    d_rs = 0; d_rt = 0; d_use_rs = 0; d_use_rt = 0;
    e_rn = 0; e_wreg = 0; e_m2reg = 0; e_alu = 0;
    m_rn = 0; m_wreg = 0; m_m2reg = 0; m_alu = 0; m_mo = 0;
    q1 = 32'h1111_0001; q2 = 32'h2222_0002; branch_taken = 0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2 resetn = 1'b0;
    @(negedge clock);
    #2 resetn = 1'b1;
  endtask

  task automatic e_load(input logic [4:0] rn);
    e_wreg = 1; e_m2reg = 1; e_rn = rn;
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clock);
    #2 resetn = 1'b1;
    #1;
    chk("reset_wpcir", wpcir1, 1'b1);
    chk("reset_cnt", sc1, 16'd0);

    // E and M both write r5: E wins
    step(); clr();
    e_wreg = 1; e_rn = 5; e_alu = 32'h11; d_rs = 5; d_use_rs = 1;
    m_wreg = 1; m_rn = 5; m_alu = 32'h22;
    #2;
    chk("lit_fwda_e", fwda1, 2'b01);
    chk("lit_da_e", da1, 32'h11);

    // M load to r7 feeds both operands
    step(); clr();
    m_wreg = 1; m_m2reg = 1; m_rn = 7; m_mo = 32'hCAFE;
    d_rs = 7; d_rt = 7; d_use_rs = 1; d_use_rt = 1;
    #2;
    chk("lit_fwda_mo", fwda1, 2'b11);
    chk("lit_fwdb_mo", fwdb1, 2'b11);
    chk("lit_db_mo", db1, 32'hCAFE);

    // load-use on r3, LD_LAT=1 vs LD_LAT=3
    do_reset();
    step(); clr(); e_load(3); d_rs = 3; d_use_rs = 1;
    #2;
    chk("lit_ld_wpcir1", wpcir1, 1'b0);
    chk("lit_ld_bubble1", dbubble1, 1'b1);
    chk("lit_ld_wpcir3_c0", wpcir3, 1'b0);
    step(); clr();
    m_wreg = 1; m_m2reg = 1; m_rn = 3; m_mo = 32'hBEEF; d_rs = 3; d_use_rs = 1;
    #2;
    chk("lit_after_wpcir1", wpcir1, 1'b1);
    chk("lit_after_fwda1", fwda1, 2'b11);
    chk("lit_after_da1", da1, 32'hBEEF);
    chk("lit_after_cnt1", sc1, 16'd1);
    chk("lit_ld_wpcir3_c1", wpcir3, 1'b0);
    step(); #2;
    chk("lit_ld_wpcir3_c2", wpcir3, 1'b0);
    step(); #2;
    chk("lit_ld_wpcir3_c3", wpcir3, 1'b1);
    chk("lit_ld_cnt3", sc3, 4'd3);

    // reset in the middle of the LD_LAT=3 stall
    step(); clr(); e_load(3); d_rs = 3; d_use_rs = 1;
    step(); clr();
    step();
    #1 resetn = 1'b0;
    #1;
    chk("lit_midreset_wpcir3", wpcir3, 1'b1);
    chk("lit_midreset_cnt3", sc3, 4'd0);
    @(negedge clock);
    #2 resetn = 1'b1;

    // unused operand and r0 loads never stall
    step(); clr(); e_load(3); d_rt = 3; d_use_rt = 0; d_rs = 1; d_use_rs = 1;
    #2;
    chk("lit_nouse_wpcir", wpcir1, 1'b1);
    step(); clr(); e_load(0); d_rs = 0; d_use_rs = 1; m_wreg = 1; m_rn = 0;
    #2;
    chk("lit_r0_wpcir", wpcir3, 1'b1);
    chk("lit_r0_fwda", fwda1, 2'b00);

    // branch flush, and branch under a load stall
    step(); clr(); branch_taken = 1;
    #2;
    chk("lit_br_flush", flush1, 1'b1);
    step(); clr();
    #2;
    chk("lit_br_gone", flush1, 1'b0);
    step(); clr(); branch_taken = 1; e_load(4); d_rt = 4; d_use_rt = 1;
    #2;
    chk("lit_br_stall_flush", flush1, 1'b0);

    // saturation: 20 consecutive stall cycles
    step(); clr();
    do_reset();
    step(); e_load(9); d_rs = 9; d_use_rs = 1;
    repeat (19) @(posedge clock);
    @(posedge clock);
    #1 clr();
    #2;
    chk("lit_sat_cnt3", sc3, 4'd15);
    chk("lit_sat_cnt1", sc1, 16'd20);

    // randomized traffic, checked by the model every cycle
    repeat (3000) begin
      step();
      d_rs = 5'($urandom_range(0, 3));
      d_rt = 5'($urandom_range(0, 3));
      d_use_rs = 1'($urandom);
      d_use_rt = 1'($urandom);
      e_rn = 5'($urandom_range(0, 3));
      e_wreg = 1'($urandom);
      e_m2reg = ($urandom_range(0, 3) == 0);
      m_rn = 5'($urandom_range(0, 3));
      m_wreg = 1'($urandom);
      m_m2reg = 1'($urandom);
      q1 = $urandom; q2 = $urandom;
      e_alu = $urandom; m_alu = $urandom; m_mo = $urandom;
      branch_taken = ($urandom_range(0, 3) == 0);
    end

    step(); clr();
    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
